sp_usb_fifo_dev: RTL and testbench

Device-side (FT245-style) responder for the synchronous 8-bit USB FIFO bus. It is the other end of the FPGA-side USB controller and is used for loopback, simulation and board-level self-test.
- Host-to-FPGA bytes are queued in an RX FIFO and offered on the bus under rxf_n / rd_n.
- FPGA-to-host bytes are accepted under txe_n / wr_n into a TX FIFO that drains to a host-side stream port.
- A programmable inactive gap after each transfer emulates the chip's recovery time.

---
 rtl/sp_usb_fifo_dev.sv | 95 +++++++++
 tb/tb_sp_usb_fifo_dev.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_usb_fifo_dev.sv
// Device-side model of a synchronous FT245-style USB FIFO: RX queue offered to the
// FPGA under rxf_n/rd_n, TX queue filled under txe_n/wr_n, with a post-transfer gap.
module sp_usb_fifo_dev #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP        = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] usb_data,
  output logic       rxf_n,
  output logic       txe_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] host_din,
  input  logic       host_write,
  output logic       host_full,
  output logic [7:0] host_dout,
  input  logic       host_read,
  output logic       host_avail,
  output logic [2:0] err_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GAP_W = $clog2(GAP + 2);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [GAP_W-1:0]    GAP_V    = GAP[GAP_W-1:0];

  logic [7:0]            rx_mem [DEPTH];
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [DEPTH_LOG2:0]   rx_count, tx_count;
  logic [GAP_W-1:0]      rx_gap, tx_gap;
  logic                  rx_push, rx_pop, tx_push, tx_pop, bus_drv;

  assign rxf_n      = (rx_count == '0) | (rx_gap != '0);
  assign txe_n      = (tx_count == FULL_CNT) | (tx_gap != '0);
  assign host_full  = (rx_count == FULL_CNT);
  assign host_avail = (tx_count != '0);
  assign host_dout  = tx_mem[tx_rp];

  // Transfers qualify on the pre-edge flags, so a full RX refuses a push even when popped.
  assign rx_push = host_write & ~host_full;
  assign rx_pop  = ~rd_n & wr_n & ~rxf_n;
  assign tx_push = ~wr_n & rd_n & ~txe_n;
  assign tx_pop  = host_read & host_avail;

  assign bus_drv  = ~rd_n & wr_n & (rx_count != '0);
  assign usb_data = bus_drv ? rx_mem[rx_rp] : 8'hzz;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= host_din;
    if (tx_push) tx_mem[tx_wp] <= usb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_gap   <= '0;
      tx_gap   <= '0;
      err_out  <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + (DEPTH_LOG2)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (DEPTH_LOG2)'(1);
      if (tx_push) tx_wp <= tx_wp + (DEPTH_LOG2)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (DEPTH_LOG2)'(1);

      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (DEPTH_LOG2+1)'(1);
        2'b01:   rx_count <= rx_count - (DEPTH_LOG2+1)'(1);
        default: rx_count <= rx_count;
      endcase
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (DEPTH_LOG2+1)'(1);
        2'b01:   tx_count <= tx_count - (DEPTH_LOG2+1)'(1);
        default: tx_count <= tx_count;
      endcase

      // A fresh transfer reloads the recovery gap rather than letting it count down.
      if (rx_pop)              rx_gap <= GAP_V;
      else if (rx_gap != '0)   rx_gap <= rx_gap - GAP_W'(1);
      if (tx_push)             tx_gap <= GAP_V;
      else if (tx_gap != '0)   tx_gap <= tx_gap - GAP_W'(1);

      if (~rd_n & rxf_n)  err_out[0] <= 1'b1;
      if (~wr_n & txe_n)  err_out[1] <= 1'b1;
      if (~rd_n & ~wr_n)  err_out[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sp_usb_fifo_dev.sv
// Scoreboard bench for sp_usb_fifo_dev: a GAP=2 instance (a) and a GAP=0 instance (b).
module tb_sp_usb_fifo_dev;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rd_n_a, wr_n_a, hw_a, hr_a, drv_a;
  logic [7:0] hdin_a, dat_a;
  logic       rxf_n_a, txe_n_a, hfull_a, havail_a;
  logic [7:0] hdout_a;
  logic [2:0] err_a;
  wire  [7:0] bus_a;
  assign bus_a = drv_a ? dat_a : 8'hzz;

  logic       rst_b, rd_n_b, wr_n_b, hw_b, hr_b, drv_b;
  logic [7:0] hdin_b, dat_b;
  logic       rxf_n_b, txe_n_b, hfull_b, havail_b;
  logic [7:0] hdout_b;
  logic [2:0] err_b;
  wire  [7:0] bus_b;
  assign bus_b = drv_b ? dat_b : 8'hzz;

  sp_usb_fifo_dev #(.DEPTH_LOG2(4), .GAP(2)) u_a (
    .clk(clk), .rst(rst_a), .usb_data(bus_a), .rxf_n(rxf_n_a), .txe_n(txe_n_a),
    .rd_n(rd_n_a), .wr_n(wr_n_a), .host_din(hdin_a), .host_write(hw_a),
    .host_full(hfull_a), .host_dout(hdout_a), .host_read(hr_a),
    .host_avail(havail_a), .err_out(err_a));

  sp_usb_fifo_dev #(.DEPTH_LOG2(4), .GAP(0)) u_b (
    .clk(clk), .rst(rst_b), .usb_data(bus_b), .rxf_n(rxf_n_b), .txe_n(txe_n_b),
    .rd_n(rd_n_b), .wr_n(wr_n_b), .host_din(hdin_b), .host_write(hw_b),
    .host_full(hfull_b), .host_dout(hdout_b), .host_read(hr_b),
    .host_avail(havail_b), .err_out(err_b));

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp_a[$];
  logic [7:0] tx_exp_a[$];
  logic [7:0] rx_exp_b[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_pop(input string name, input logic [7:0] act, inout logic [7:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=%h expected=<none queued>", name, act);
    end else begin
      chk(name, act, q.pop_front());
    end
  endtask

  // Monitor: compares every byte the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst_a && !rd_n_a && wr_n_a && !rxf_n_a) chk_pop("a_bus_read", bus_a, rx_exp_a);
    if (!rst_a && hr_a && havail_a)             chk_pop("a_host_dout", hdout_a, tx_exp_a);
    if (!rst_b && !rd_n_b && wr_n_b && !rxf_n_b) chk_pop("b_bus_read", bus_b, rx_exp_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    rx_exp_a.delete();
    tx_exp_a.delete();
  endtask

  task automatic fill_tx(input logic [7:0] base);
    logic [7:0] nxt;
    int sent;
    int guard;
    nxt = base;
    sent = 0;
    guard = 0;
    while (sent < 16 && guard < 200) begin
      if (!txe_n_a) begin
        wr_n_a = 1'b0; drv_a = 1'b1; dat_a = nxt;
        tx_exp_a.push_back(nxt);
        nxt = nxt + 8'd1;
        sent++;
      end else begin
        wr_n_a = 1'b1; drv_a = 1'b0;
      end
      tick();
      guard++;
    end
    wr_n_a = 1'b1; drv_a = 1'b0;
    chk("fill_tx_count", 8'(sent), 8'd16);
  endtask

  task automatic drain_tx();
    hr_a = 1'b1;
    repeat (16) tick();
    hr_a = 1'b0;
    chk("drain_tx_left", 8'(tx_exp_a.size()), 8'd0);
    chk("drain_tx_avail", {7'd0, havail_a}, 8'd0);
  endtask

  task automatic drain_rx(input int n);
    int pops;
    int guard;
    pops = 0;
    guard = 0;
    while (pops < n && guard < 200) begin
      if (!rxf_n_a) begin
        rd_n_a = 1'b0;
        pops++;
      end else begin
        rd_n_a = 1'b1;
      end
      tick();
      guard++;
    end
    rd_n_a = 1'b1;
    chk("drain_rx_count", 8'(pops), 8'(n));
  endtask

  initial begin
    rst_a = 1'b1; rd_n_a = 1'b1; wr_n_a = 1'b1; hw_a = 1'b0; hr_a = 1'b0;
    drv_a = 1'b0; hdin_a = '0; dat_a = '0;
    rst_b = 1'b1; rd_n_b = 1'b1; wr_n_b = 1'b1; hw_b = 1'b0; hr_b = 1'b0;
    drv_b = 1'b0; hdin_b = '0; dat_b = '0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    chk("rst_rxf_n", {7'd0, rxf_n_a}, 8'd1);
    chk("rst_txe_n", {7'd0, txe_n_a}, 8'd0);
    chk("rst_host_full", {7'd0, hfull_a}, 8'd0);
    chk("rst_host_avail", {7'd0, havail_a}, 8'd0);
    chk("rst_err", {5'd0, err_a}, 8'd0);
    chk("rst_b_rxf_n", {7'd0, rxf_n_b}, 8'd1);

    // Two host bytes read back over the bus with a 2-cycle recovery gap.
    hw_a = 1'b1; hdin_a = 8'hA5; rx_exp_a.push_back(8'hA5);
    tick();
    chk("rxf_after_write", {7'd0, rxf_n_a}, 8'd0);
    hdin_a = 8'h3C; rx_exp_a.push_back(8'h3C); rd_n_a = 1'b0;
    tick();
    hw_a = 1'b0; rd_n_a = 1'b1;
    chk("gap_cycle1", {7'd0, rxf_n_a}, 8'd1);
    tick();
    chk("gap_cycle2", {7'd0, rxf_n_a}, 8'd1);
    tick();
    chk("gap_end", {7'd0, rxf_n_a}, 8'd0);
    rd_n_a = 1'b0;
    tick();
    rd_n_a = 1'b1;
    chk("rxf_after_second", {7'd0, rxf_n_a}, 8'd1);
    repeat (3) tick();
    chk("rx_empty", {7'd0, rxf_n_a}, 8'd1);

    // Bus must stay released while the FIFO holds data but rd_n is high.
    hw_a = 1'b1; hdin_a = 8'h42; rx_exp_a.push_back(8'h42);
    tick();
    hw_a = 1'b0; drv_a = 1'b1; dat_a = 8'h00;
    #1 chk("bus_z_idle", bus_a, 8'h00);
    drv_a = 1'b0;
    rd_n_a = 1'b0;
    tick();
    rd_n_a = 1'b1;
    repeat (3) tick();

    // TX fill 0x11..0x20, then host drains in order.
    fill_tx(8'h11);
    chk("tx_full_txe", {7'd0, txe_n_a}, 8'd1);
    chk("tx_avail", {7'd0, havail_a}, 8'd1);
    chk("tx_head", hdout_a, 8'h11);
    repeat (4) tick();
    chk("tx_full_after_gap", {7'd0, txe_n_a}, 8'd1);
    drain_tx();
    chk("txe_after_drain", {7'd0, txe_n_a}, 8'd0);

    // RX full boundary.
    reset_a();
    hw_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      hdin_a = 8'hB0 + 8'(i);
      rx_exp_a.push_back(hdin_a);
      tick();
    end
    hw_a = 1'b0;
    chk("rx_full", {7'd0, hfull_a}, 8'd1);
    hw_a = 1'b1; hdin_a = 8'hEE;
    tick();
    chk("rx_full_17th", {7'd0, hfull_a}, 8'd1);
    rd_n_a = 1'b0; hdin_a = 8'h77;
    tick();
    rd_n_a = 1'b1; hw_a = 1'b0;
    chk("rx_full_pop_push", {7'd0, hfull_a}, 8'd0);
    drain_rx(15);
    repeat (4) tick();
    chk("rx_no_extra", {7'd0, rxf_n_a}, 8'd1);
    chk("rx_queue_done", 8'(rx_exp_a.size()), 8'd0);

    // Protocol errors.
    reset_a();
    rd_n_a = 1'b0;
    tick();
    rd_n_a = 1'b1;
    chk("err_rd_empty", {5'd0, err_a}, 8'h01);
    chk("err_rd_no_pop", {7'd0, rxf_n_a}, 8'd1);
    reset_a();
    fill_tx(8'h60);
    wr_n_a = 1'b0; drv_a = 1'b1; dat_a = 8'h99;
    tick();
    wr_n_a = 1'b1; drv_a = 1'b0;
    chk("err_wr_full", {5'd0, err_a}, 8'h02);
    drain_tx();
    hw_a = 1'b1; hdin_a = 8'h5C;
    tick();
    hw_a = 1'b0;
    rd_n_a = 1'b0; wr_n_a = 1'b0; drv_a = 1'b1; dat_a = 8'h5A;
    #1 chk("bus_z_both_low", bus_a, 8'h5A);
    tick();
    rd_n_a = 1'b1; wr_n_a = 1'b1; drv_a = 1'b0;
    chk("err_both_low", {5'd0, err_a}, 8'h06);
    chk("both_low_no_pop", {7'd0, rxf_n_a}, 8'd0);
    chk("both_low_no_push", {7'd0, havail_a}, 8'd0);
    reset_a();
    chk("err_cleared", {5'd0, err_a}, 8'h00);

    // GAP=0: back-to-back reads, then reset mid-burst.
    hw_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      hdin_b = 8'hC0 + 8'(i);
      rx_exp_b.push_back(hdin_b);
      tick();
    end
    hw_b = 1'b0;
    rd_n_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b_rxf_burst", {7'd0, rxf_n_b}, 8'd0);
      tick();
    end
    chk("b_popped_8", 8'(rx_exp_b.size()), 8'd4);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0; rd_n_b = 1'b1;
    rx_exp_b.delete();
    chk("b_rst_rxf_n", {7'd0, rxf_n_b}, 8'd1);
    repeat (2) tick();
    chk("b_rst_discard", {7'd0, rxf_n_b}, 8'd1);
    chk("b_rst_full", {7'd0, hfull_b}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
